// File: rtl/queue_if.sv
// Producer/consumer bundle for the queue: write request, pop request, head data
// and occupancy/error status.
interface queue_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SIZE  = 20
);
  localparam int CW = $clog2(FIFO_SIZE + 1);

  // insert and pop are level requests sampled on every rising edge; there is no
  // ready signal, so a request the queue cannot honour is dropped and reported
  // one cycle later on overflow/underflow.
  logic [DATA_WIDTH-1:0] entry;
  logic                  insert;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output entry, insert, pop,
    input  head, full, empty, count, overflow, underflow
  );

  modport slave (
    input  entry, insert, pop,
    output head, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/queue.sv
// First-word fall-through FIFO with occupancy count and one-cycle error pulses.
// Pointers wrap by explicit compare so FIFO_SIZE need not be a power of two.
module queue #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SIZE  = 20
) (
  input logic    clk,
  input logic    rst,
  queue_if.slave q
);
  localparam int              CW   = $clog2(FIFO_SIZE + 1);
  localparam int              PW   = $clog2(FIFO_SIZE);
  localparam logic [PW-1:0]   LAST = PW'(FIFO_SIZE - 1);
  localparam logic [CW-1:0]   SIZE = CW'(FIFO_SIZE);

  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (count == SIZE);
  assign empty = (count == '0);

  // A simultaneous pop frees the head slot, so a full queue still takes the write.
  assign wr_ok = q.insert & (~full | q.pop);
  assign rd_ok = q.pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= q.insert & ~wr_ok;
      underflow <= q.pop & ~rd_ok;
    end
  end

  // Storage is deliberately left out of reset; head is gated by empty instead.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= q.entry;
    end
  end

  assign q.head      = empty ? '0 : mem[rd_ptr];
  assign q.full      = full;
  assign q.empty     = empty;
  assign q.count     = count;
  assign q.overflow  = overflow;
  assign q.underflow = underflow;
endmodule
